// File: rtl/pulse_demux_pkg.sv
// Shared definitions for pulse_demux: slot FSM encoding and slot timer width.
package pulse_demux_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder used to form the channel drive pattern.
module onehot_dec
  import pulse_demux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [SEL_W-1:0] i_sel,
  output logic [N_CH-1:0]  o_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_bit
      assign o_onehot[gi] = (i_sel == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/pulse_demux.sv
// Routes each accepted symbol to a PULSE_W-cycle one-hot pulse on one channel,
// followed by a forced GAP_W-cycle low gap; blank symbols occupy the slot silently.
module pulse_demux
  import pulse_demux_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int SEL_W   = $clog2(N_CH),
  parameter int PULSE_W = 3,
  parameter int GAP_W   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_blank,
  output logic             in_ready,
  output logic [N_CH-1:0]  out_ch,
  output logic             busy,
  output logic [15:0]      sym_count
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [SEL_W-1:0] r_sel, w_sel_next;
  logic             r_blank, w_blank_next;
  logic [N_CH-1:0]  r_out_ch, w_out_ch_next;
  logic [N_CH-1:0]  w_dec;
  logic [15:0]      r_sym_count;
  logic             w_accept;

  assign in_ready = (r_state == ST_IDLE) && enable;
  assign w_accept = in_valid && in_ready;

  // Decode the select that will be current next cycle, so out_ch can be registered.
  onehot_dec #(
    .N_CH (N_CH),
    .SEL_W(SEL_W)
  ) u_dec (
    .i_sel   (w_sel_next),
    .o_onehot(w_dec)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sel_next   = r_sel;
    w_blank_next = r_blank;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_PULSE;
          w_cnt_next   = PULSE_LOAD;
          w_sel_next   = in_sel;
          w_blank_next = in_blank;
        end
      end
      ST_PULSE: begin
        if (r_cnt == '0) begin
          if (GAP_W > 0) begin
            w_state_next = ST_GAP;
            w_cnt_next   = GAP_LOAD;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_out_ch_next = ((w_state_next == ST_PULSE) && !w_blank_next) ? w_dec : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_blank     <= 1'b0;
      r_out_ch    <= '0;
      r_sym_count <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_sel    <= w_sel_next;
      r_blank  <= w_blank_next;
      r_out_ch <= w_out_ch_next;
      if (w_accept) begin
        r_sym_count <= r_sym_count + 16'd1;
      end
    end
  end

  assign out_ch    = r_out_ch;
  assign busy      = (r_state != ST_IDLE);
  assign sym_count = r_sym_count;

endmodule

// File: tb/tb_pulse_demux.sv
// Self-checking bench for pulse_demux: directed scenarios plus random traffic against a slot-timing model.
module tb_pulse_demux;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int PW    = 3;
  localparam int GW    = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             in_valid;
  logic [SEL_W-1:0] in_sel;
  logic             in_blank;
  logic             in_ready;
  logic [N_CH-1:0]  out_ch;
  logic             busy;
  logic [15:0]      sym_count;

  int n_vec = 0;
  int n_err = 0;

  // Model: a slot accepted in cycle t pulses during t+1..t+PW and blocks until t+PW+GW+1.
  int              cyc     = 0;
  int              free_at = 0;
  int              p_lo    = 0;
  int              p_hi    = -1;
  logic [N_CH-1:0] p_val   = '0;
  logic [15:0]     m_count = '0;
  logic            m_acc;
  logic            exp_ready, exp_busy;
  logic [N_CH-1:0] exp_out;

  always #5 clk = ~clk;

  pulse_demux #(
    .N_CH   (N_CH),
    .SEL_W  (SEL_W),
    .PULSE_W(PW),
    .GAP_W  (GW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .in_valid (in_valid),
    .in_sel   (in_sel),
    .in_blank (in_blank),
    .in_ready (in_ready),
    .out_ch   (out_ch),
    .busy     (busy),
    .sym_count(sym_count)
  );

  task automatic sample();
    @(negedge clk);
    exp_ready = enable && (cyc >= free_at);
    exp_out   = (cyc >= p_lo && cyc <= p_hi) ? p_val : '0;
    exp_busy  = (cyc < free_at);
  endtask

  task automatic advance();
    logic [SEL_W-1:0] s;
    logic             b;
    m_acc = rst_n && in_valid && enable && (cyc >= free_at);
    s = in_sel;
    b = in_blank;
    @(posedge clk);
    cyc++;
    if (m_acc) begin
      p_lo    = cyc;
      p_hi    = cyc + PW - 1;
      p_val   = b ? '0 : (N_CH'(1) << s);
      free_at = cyc + PW + GW;
      m_count = m_count + 16'd1;
    end
    #1;
  endtask

  task automatic wait_idle();
    in_valid = 1'b0;
    for (int i = 0; i < 12 && cyc < free_at; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      sample();
      n_vec++; if (out_ch !== 4'b0000) begin n_err++; $display("FAIL reset out_ch got=%b exp=0000", out_ch); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got=%b exp=0", busy); end
      n_vec++; if (sym_count !== 16'd0) begin n_err++; $display("FAIL reset sym_count got=%0d exp=0", sym_count); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
      advance();
    end
    rst_n  = 1'b1;
    enable = 1'b0;
    sample();
    n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL reset_release ready_off got=%b exp=%b", in_ready, exp_ready); end
    advance();
    enable = 1'b1;
    sample();
    n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL reset_release ready_on got=%b exp=%b", in_ready, exp_ready); end
    advance();
  endtask

  task automatic test_stream();
    logic [SEL_W-1:0] seq [3];
    int               acc_t [3];
    int               idx;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd3;
    acc_t = '{default: 0};
    idx = 0;
    wait_idle();
    in_valid = 1'b1; in_blank = 1'b0; in_sel = seq[0];
    for (int i = 0; i < 30 && idx < 3; i++) begin
      sample();
      n_vec++; if (out_ch !== exp_out) begin n_err++; $display("FAIL stream out_ch cyc=%0d got=%b exp=%b", cyc, out_ch, exp_out); end
      n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL stream in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready); end
      if (in_ready && in_valid) acc_t[idx] = cyc;
      advance();
      if (m_acc) begin
        idx++;
        if (idx < 3) in_sel = seq[idx];
        else in_valid = 1'b0;
      end
    end
    n_vec++; if (idx != 3) begin n_err++; $display("FAIL stream timeout accepts=%0d exp=3", idx); end
    for (int k = 1; k < 3; k++) begin
      n_vec++; if (acc_t[k] - acc_t[k-1] != PW + GW + 1) begin
        n_err++; $display("FAIL stream spacing got=%0d exp=%0d", acc_t[k] - acc_t[k-1], PW + GW + 1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      sample();
      n_vec++; if (out_ch !== exp_out) begin n_err++; $display("FAIL stream_tail out_ch cyc=%0d got=%b exp=%b", cyc, out_ch, exp_out); end
      advance();
    end
    n_vec++; if (sym_count !== 16'd3) begin n_err++; $display("FAIL stream sym_count got=%0d exp=3", sym_count); end
  endtask

  task automatic test_single();
    wait_idle();
    in_valid = 1'b1; in_sel = 2'd2; in_blank = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample();
      n_vec++; if (out_ch !== exp_out) begin n_err++; $display("FAIL single out_ch cyc=%0d got=%b exp=%b", cyc, out_ch, exp_out); end
      n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL single busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL single in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready); end
      advance();
      if (m_acc) begin in_valid = 1'b0; in_sel = 2'd1; end
    end
  endtask

  task automatic test_blank();
    wait_idle();
    in_valid = 1'b1; in_sel = 2'd1; in_blank = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sample();
      n_vec++; if (out_ch !== exp_out) begin n_err++; $display("FAIL blank out_ch cyc=%0d got=%b exp=%b", cyc, out_ch, exp_out); end
      n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL blank busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      n_vec++; if (sym_count !== m_count) begin n_err++; $display("FAIL blank sym_count cyc=%0d got=%0d exp=%0d", cyc, sym_count, m_count); end
      advance();
      if (m_acc) begin in_valid = 1'b0; in_blank = 1'b0; end
    end
  endtask

  task automatic test_enable_drop();
    bit accepted;
    accepted = 1'b0;
    wait_idle();
    in_valid = 1'b1; in_sel = 2'd3; in_blank = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample();
      n_vec++; if (out_ch !== exp_out) begin n_err++; $display("FAIL en_drop out_ch cyc=%0d got=%b exp=%b", cyc, out_ch, exp_out); end
      n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL en_drop in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready); end
      n_vec++; if (sym_count !== m_count) begin n_err++; $display("FAIL en_drop sym_count cyc=%0d got=%0d exp=%0d", cyc, sym_count, m_count); end
      advance();
      if (m_acc) accepted = 1'b1;
      if (accepted) enable = 1'b0;
    end
    in_valid = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    wait_idle();
    in_valid = 1'b1; in_sel = 2'd1; in_blank = 1'b0;
    sample(); advance();
    in_valid = 1'b0;
    sample(); advance();
    // Now in the second pulse cycle: the pulse must be up before reset hits.
    n_vec++; if (out_ch !== 4'b0010) begin n_err++; $display("FAIL reset_mid pre out_ch got=%b exp=0010", out_ch); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_ch !== 4'b0000) begin n_err++; $display("FAIL reset_mid async out_ch got=%b exp=0000", out_ch); end
    n_vec++; if (sym_count !== 16'd0) begin n_err++; $display("FAIL reset_mid sym_count got=%0d exp=0", sym_count); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_mid busy got=%b exp=0", busy); end
    p_hi = -1; free_at = cyc; m_count = '0;
    sample(); advance();
    rst_n = 1'b1;
    sample();
    n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL reset_mid in_ready got=%b exp=%b", in_ready, exp_ready); end
    advance();
  endtask

  task automatic test_wrap();
    wait_idle();
    force dut.r_sym_count = 16'hFFFF;
    #1;
    release dut.r_sym_count;
    m_count = 16'hFFFF;
    in_valid = 1'b1; in_sel = 2'd0; in_blank = 1'b0;
    sample();
    n_vec++; if (sym_count !== m_count) begin n_err++; $display("FAIL wrap preload got=%0d exp=%0d", sym_count, m_count); end
    advance();
    in_valid = 1'b0;
    sample();
    n_vec++; if (sym_count !== 16'd0) begin n_err++; $display("FAIL wrap sym_count got=%0d exp=0", sym_count); end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_sel   = SEL_W'($urandom_range(0, N_CH - 1));
      in_blank = ($urandom_range(0, 3) == 0);
      enable   = ($urandom_range(0, 19) < 17);
      sample();
      n_vec++; if (out_ch !== exp_out) begin n_err++; $display("FAIL random out_ch cyc=%0d got=%b exp=%b", cyc, out_ch, exp_out); end
      n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL random busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      n_vec++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL random in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready); end
      n_vec++; if (sym_count !== m_count) begin n_err++; $display("FAIL random sym_count cyc=%0d got=%0d exp=%0d", cyc, sym_count, m_count); end
      advance();
    end
    in_valid = 1'b0;
    enable   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_sel = '0; in_blank = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_single();
    test_blank();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pulse_demux.md
PULSE_DEMUX -- requirements
Module: pulse_demux

Interface
REQ-001 Parameter N_CH, default 4, is the number of output channels; it SHALL be a power of two in the range 2..16.
REQ-002 Parameter SEL_W, default $clog2(N_CH), is the width of the channel select.
REQ-003 Parameter PULSE_W, default 3, is the pulse length in clock cycles; legal range 1..255.
REQ-004 Parameter GAP_W, default 1, is the forced low gap after each slot in clock cycles; legal range 0..255.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 enable  input  1  when 1, new symbols may be accepted.
REQ-008 in_valid  input  1  a symbol is presented.
REQ-009 in_sel  input  SEL_W  target channel index of the symbol.
REQ-010 in_blank  input  1  when 1, the symbol is an empty slot (no pulse on any channel).
REQ-011 in_ready  output  1  the block accepts a symbol this cycle.
REQ-012 out_ch  output  N_CH  registered one-hot channel drive; all zero when idle.
REQ-013 busy  output  1  a slot (pulse or gap) is in progress.
REQ-014 sym_count  output  16  count of accepted symbols.

Function
REQ-015 A symbol SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL equal (state==IDLE) AND enable, combinationally.
REQ-017 FSM states SHALL be IDLE, PULSE and GAP.
- IDLE -> PULSE on accept.
- PULSE -> GAP after PULSE_W cycles when GAP_W>0; otherwise PULSE -> IDLE.
- GAP -> IDLE after GAP_W cycles.
REQ-018 On accept with in_blank=0, out_ch SHALL equal one-hot(in_sel) from the next cycle for exactly PULSE_W cycles.
REQ-019 On accept with in_blank=1, the slot SHALL consume the same PULSE_W+GAP_W cycles with out_ch all zero.
REQ-020 in_sel and in_blank SHALL be latched at accept; later input changes SHALL NOT affect the current slot.
REQ-021 out_ch SHALL be zero in IDLE and GAP, and SHALL never have more than one bit set.
REQ-022 busy SHALL be 1 in PULSE and GAP, and 0 in IDLE.
REQ-023 The minimum accept-to-accept spacing SHALL be PULSE_W+GAP_W+1 cycles.
REQ-024 sym_count SHALL increment by 1 on every accept, including blanks, and SHALL wrap from 65535 to 0.
REQ-025 Deasserting enable during PULSE or GAP SHALL NOT truncate the slot; it only blocks the next accept.
REQ-026 A 16-bit... no: an 8-bit down-counter SHALL time both PULSE and GAP; it is loaded with PULSE_W-1 on accept and with GAP_W-1 on PULSE exit.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state=IDLE, out_ch=0, busy=0, sym_count=0, the timing counter to 0, and the latched select/blank to 0.
REQ-028 Reset asserted mid-pulse SHALL drop out_ch to 0 immediately, without waiting for a clock edge.
REQ-029 After rst_n rises, in_ready SHALL follow enable from the first clock edge.

Structure
REQ-030 The FSM state encoding and the count-width constant (8) SHALL reside in the shared package pulse_demux_pkg.
REQ-031 Sub-module onehot_dec (SEL_W -> N_CH one-hot decoder, combinational) SHALL be instantiated once; all other logic is in pulse_demux.

Verification
REQ-032 Bench uses N_CH=4, PULSE_W=3, GAP_W=1. Scenarios:
- Accept sel=2, blank=0 at cycle t -> out_ch=4'b0100 during t+1..t+3, 0 at t+4, in_ready=1 again at t+5.
- in_valid held high with the stream sel=0,1,3 -> accepts spaced 5 cycles apart; out_ch shows 0001, 0010, 1000; sym_count=3.
- Blank symbol (sel=1, blank=1) -> out_ch stays 0 for 4 cycles, busy=1 for 4 cycles, sym_count increments.
- enable dropped one cycle after accept of sel=3 -> full 3-cycle 1000 pulse, then no further accept while enable=0.
- rst_n pulled low in the second pulse cycle -> out_ch=0 immediately; sym_count=0; state returns to IDLE.
- Preload 65535 accepts, or force sym_count=65535, then one accept -> sym_count=0.
